// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  // Bit offsets of plane 0 for each colour inside a framebuffer word
  localparam int R0_OFS = 20;
  localparam int G0_OFS = 16;
  localparam int B0_OFS = 12;
  localparam int R1_OFS = 8;
  localparam int G1_OFS = 4;
  localparam int B1_OFS = 0;

  // Default panel geometry and derived sizes
  localparam int DEF_WIDTH     = 96;
  localparam int DEF_HEIGHT    = 48;
  localparam int DEF_BPP       = 12;
  localparam int DEF_CHAINED   = 1;
  localparam int DEF_BASE_TIME = 8;

  localparam int NCOL   = DEF_WIDTH * DEF_CHAINED;
  localparam int ROWS   = DEF_HEIGHT / 2;
  localparam int PLANES = DEF_BPP / 3;

  localparam int ADDR_W = 12;
  localparam int ROW_W  = 5;
  localparam int DAT_W  = 24;
  localparam int TMR_W  = 16;
  localparam int BRT_W  = 8;

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Framebuffer read port and HUB75 panel pins of the scan controller.
interface hub75_scan_ctrl_if;

  logic [hub75_pkg::ADDR_W-1:0] mem_addr;
  logic                         mem_re;
  logic [hub75_pkg::DAT_W-1:0]  mem_dat;
  logic                         r0, g0, b0, r1, g1, b1;
  logic                         panel_clk;
  logic                         panel_lat;
  logic                         panel_oe_n;
  logic [hub75_pkg::ROW_W-1:0]  row_addr;

  // Controller side
  modport master (
    output mem_addr, mem_re, r0, g0, b0, r1, g1, b1,
    output panel_clk, panel_lat, panel_oe_n, row_addr,
    input  mem_dat
  );

  // Memory / panel side
  modport slave (
    input  mem_addr, mem_re, r0, g0, b0, r1, g1, b1,
    input  panel_clk, panel_lat, panel_oe_n, row_addr,
    output mem_dat
  );

endinterface

// File: rtl/hub75_bcm_timer.sv
// BCM display timer: down-counts the on-time of one bit plane.
// Optional macro HUB75_BRIGHTNESS_EN scales the output-enable window.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BASE_TIME = DEF_BASE_TIME,
  parameter int PLANE_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [BRT_W-1:0]   brightness,
`endif
  output logic               done,
  output logic               oe_on    // output enable for the coming cycle
);

  logic [TMR_W-1:0] len;
  logic [TMR_W-1:0] thr;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] on_q, on_d;

  assign len = TMR_W'(BASE_TIME) << plane;

`ifdef HUB75_BRIGHTNESS_EN
  logic [15:0] prod;
  assign prod = len * {8'd0, brightness};
  assign thr  = prod >> 8;
`else
  assign thr  = len;
`endif

  assign done  = (cnt_q == '0);
  assign oe_on = load ? (thr != '0) : (on_q > TMR_W'(1));

  // Next counter values: load plane length, then count both down to zero
  always_comb begin
    cnt_d = cnt_q;
    on_d  = on_q;
    if (load) begin
      cnt_d = len - 1'b1;
      on_d  = thr;
    end else if (run && !done) begin
      cnt_d = cnt_q - 1'b1;
      if (on_q != '0) on_d = on_q - 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      on_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: fetches framebuffer words, shifts one BCM plane
// per row pair, latches it and displays it for BASE_TIME<<plane cycles.
// Optional macro HUB75_BRIGHTNESS_EN adds a global brightness input.
//
// state      | meaning
// IDLE       | waiting for enable, panel dark
// FETCH      | 2 cycles, first column of the row requested
// SHIFT      | 2 cycles per column: data out + clk low, then clk high
// BLANK      | 1 cycle, shift clock parked low
// LATCH      | 1 cycle, latch strobe and row select update
// DISPLAY    | plane on-time, output enable active
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int BPP       = DEF_BPP,
  parameter int CHAINED   = DEF_CHAINED,
  parameter int BASE_TIME = DEF_BASE_TIME
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [BRT_W-1:0]   brightness,
`endif
  hub75_scan_ctrl_if.master  bus,
  output logic               busy,
  output logic               frame_done
);

  localparam int N_COL    = WIDTH * CHAINED;
  localparam int N_ROWS   = HEIGHT / 2;
  localparam int N_PLANES = BPP / 3;
  localparam int COL_W    = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int PLANE_W  = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(N_COL - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(N_PLANES - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(N_ROWS - 1);

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    return ADDR_W'(int'(r) * N_COL);
  endfunction

  state_e              state_q, state_d;
  logic                fcnt_q, fcnt_d;
  logic                phase_q, phase_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_re_q, mem_re_d;
  logic [5:0]          rgb_q, rgb_d;
  logic                panel_clk_q, panel_clk_d;
  logic                panel_lat_q, panel_lat_d;
  logic                panel_oe_n_q, panel_oe_n_d;
  logic [ROW_W-1:0]    row_addr_q, row_addr_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                go_fetch, load_col, frame_start;
  logic                tmr_load, tmr_done, tmr_oe_on;
  logic [5:0]          plane_bits;

`ifdef HUB75_BRIGHTNESS_EN
  logic [BRT_W-1:0]    bright_q, bright_d;
`endif

  assign plane_bits = {bus.mem_dat[5'(R0_OFS) + 5'(plane_q)],
                       bus.mem_dat[5'(G0_OFS) + 5'(plane_q)],
                       bus.mem_dat[5'(B0_OFS) + 5'(plane_q)],
                       bus.mem_dat[5'(R1_OFS) + 5'(plane_q)],
                       bus.mem_dat[5'(G1_OFS) + 5'(plane_q)],
                       bus.mem_dat[5'(B1_OFS) + 5'(plane_q)]};

  hub75_bcm_timer #(
    .BASE_TIME (BASE_TIME),
    .PLANE_W   (PLANE_W)
  ) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .run        (state_q == ST_DISPLAY),
    .plane      (plane_q),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (bright_q),
`endif
    .done       (tmr_done),
    .oe_on      (tmr_oe_on)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    phase_d      = phase_q;
    col_d        = col_q;
    row_d        = row_q;
    plane_d      = plane_q;
    mem_addr_d   = mem_addr_q;
    mem_re_d     = mem_re_q;
    rgb_d        = rgb_q;
    panel_clk_d  = panel_clk_q;
    panel_lat_d  = 1'b0;
    panel_oe_n_d = 1'b1;
    row_addr_d   = row_addr_q;
    frame_done_d = 1'b0;
    go_fetch     = 1'b0;
    load_col     = 1'b0;
    frame_start  = 1'b0;
    tmr_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          row_d       = '0;
          plane_d     = '0;
          go_fetch    = 1'b1;
          frame_start = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!fcnt_q) begin
          fcnt_d = 1'b1;
        end else begin
          state_d  = ST_SHIFT;
          col_d    = '0;
          phase_d  = 1'b0;
          load_col = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d     = 1'b1;
          panel_clk_d = 1'b1;
        end else if (col_q != COL_LAST) begin
          col_d    = col_q + 1'b1;
          phase_d  = 1'b0;
          load_col = 1'b1;
        end else begin
          state_d     = ST_BLANK;
          panel_clk_d = 1'b0;
        end
      end
      ST_BLANK: begin
        state_d     = ST_LATCH;
        panel_lat_d = 1'b1;
        row_addr_d  = row_q;
      end
      ST_LATCH: begin
        state_d      = ST_DISPLAY;
        tmr_load     = 1'b1;
        panel_oe_n_d = !tmr_oe_on;
      end
      ST_DISPLAY: begin
        if (!tmr_done) begin
          panel_oe_n_d = !tmr_oe_on;
        end else if (plane_q != PLANE_LAST) begin
          plane_d  = plane_q + 1'b1;
          go_fetch = 1'b1;
        end else begin
          plane_d = '0;
          if (row_q != ROW_LAST) begin
            row_d    = row_q + 1'b1;
            go_fetch = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            row_d        = '0;
            if (enable) begin
              go_fetch    = 1'b1;
              frame_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Request the first word of the row; the data lands as SHIFT starts
    if (go_fetch) begin
      state_d    = ST_FETCH;
      fcnt_d     = 1'b0;
      mem_addr_d = row_base(row_d);
      mem_re_d   = 1'b1;
    end

    // Present column col_d and prefetch the next one, if any
    if (load_col) begin
      rgb_d       = plane_bits;
      panel_clk_d = 1'b0;
      if (col_d != COL_LAST) begin
        mem_addr_d = mem_addr_q + 1'b1;
        mem_re_d   = 1'b1;
      end else begin
        mem_re_d   = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

`ifdef HUB75_BRIGHTNESS_EN
  // Brightness is frozen for a whole frame
  always_comb begin
    bright_d = bright_q;
    if (frame_start) bright_d = brightness;
  end
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= 1'b0;
      phase_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      rgb_q        <= '0;
      panel_clk_q  <= 1'b0;
      panel_lat_q  <= 1'b0;
      panel_oe_n_q <= 1'b1;
      row_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      rgb_q        <= rgb_d;
      panel_clk_q  <= panel_clk_d;
      panel_lat_q  <= panel_lat_d;
      panel_oe_n_q <= panel_oe_n_d;
      row_addr_q   <= row_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_re     = mem_re_q;
  assign {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1} = rgb_q;
  assign bus.panel_clk  = panel_clk_q;
  assign bus.panel_lat  = panel_lat_q;
  assign bus.panel_oe_n = panel_oe_n_q;
  assign bus.row_addr   = row_addr_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl at default geometry.
module tb_hub75_scan_ctrl;

  localparam int NC    = 96;
  localparam int NR    = 24;
  localparam int NP    = 4;
  localparam int BT    = 8;
  localparam int FRAME = 21696;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;
  logic frame_done;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] brightness;
`endif

  hub75_scan_ctrl_if bus ();

  hub75_scan_ctrl #(
    .WIDTH (96), .HEIGHT (48), .BPP (12), .CHAINED (1), .BASE_TIME (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer model: registered read, data usable two edges after address
  logic [23:0] fb [0:4095];
  always @(posedge clk) if (bus.mem_re) bus.mem_dat <= fb[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [6:0] rgb_q [$];
  int         lat_q [$];
  int         oe_q  [$];

  function automatic int on_len(input int p);
`ifdef HUB75_BRIGHTNESS_EN
    return ((BT << p) * 128) >> 8;
`else
    return BT << p;
`endif
  endfunction

  task automatic push_frame();
    logic [23:0] w;
    for (int r = 0; r < NR; r++) begin
      for (int p = 0; p < NP; p++) begin
        for (int c = 0; c < NC; c++) begin
          w = fb[r * NC + c];
          rgb_q.push_back({1'b1, w[20+p], w[16+p], w[12+p], w[8+p], w[4+p], w[p]});
        end
        lat_q.push_back(r);
        oe_q.push_back(on_len(p));
      end
    end
  endtask

  // Output monitor, sampled on the falling edge
  logic mon_en = 1'b0;
  logic prev_clk = 1'b0;
  logic prev_busy = 1'b0;
  int   rises = 0;
  int   low_cnt = 0;
  int   done_cnt = 0;
  int   start_cyc = 0;
  int   last_done = 0;
  logic [6:0] exp_rgb;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.panel_clk && !prev_clk) begin
        rises++;
        chk("rgb_q_nonempty", 32'(rgb_q.size() != 0), 32'd1);
        if (rgb_q.size() != 0) begin
          exp_rgb = rgb_q.pop_front();
          chk("rgb", 32'({bus.panel_oe_n, bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1}),
              32'(exp_rgb));
        end
      end
      if (bus.panel_lat) begin
        chk("lat_oe_n", 32'(bus.panel_oe_n), 32'd1);
        chk("clk_edges", 32'(rises), 32'(NC));
        rises = 0;
        chk("lat_q_nonempty", 32'(lat_q.size() != 0), 32'd1);
        if (lat_q.size() != 0) chk("lat_row", 32'(bus.row_addr), 32'(lat_q.pop_front()));
      end
      if (!bus.panel_oe_n) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        chk("oe_q_nonempty", 32'(oe_q.size() != 0), 32'd1);
        if (oe_q.size() != 0) chk("oe_low_len", 32'(low_cnt), 32'(oe_q.pop_front()));
        low_cnt = 0;
      end
      if (busy && !prev_busy) start_cyc = cyc;
      if (frame_done) begin
        if (done_cnt == 0) chk("frame_len", 32'(cyc - start_cyc), 32'(FRAME));
        else               chk("frame_period", 32'(cyc - last_done), 32'(FRAME));
        last_done = cyc;
        done_cnt++;
      end
      prev_clk  = bus.panel_clk;
      prev_busy = busy;
    end
  end

  initial begin
    int k;
    rst    = 1'b1;
    enable = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd128;
`endif
    for (int i = 0; i < 4096; i++) fb[i] = (i < NR * NC) ? 24'($urandom) : 24'h0;
    fb[0] = 24'hF0F00F;
    fb[1] = 24'hF0F00F;

    repeat (3) @(negedge clk);
    chk("rst_oe_n",       32'(bus.panel_oe_n), 32'd1);
    chk("rst_busy",       32'(busy),           32'd0);
    chk("rst_mem_re",     32'(bus.mem_re),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_panel_clk",  32'(bus.panel_clk),  32'd0);
    chk("rst_panel_lat",  32'(bus.panel_lat),  32'd0);
    chk("rst_row_addr",   32'(bus.row_addr),   32'd0);
    chk("rst_frame_done", 32'(frame_done),     32'd0);
    chk("rst_rgb", 32'({bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1}), 32'd0);

    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold_busy", 32'(busy), 32'd0);

    // Two back-to-back frames; enable dropped during row 10 of the second
    push_frame();
    push_frame();
    mon_en = 1'b1;
    enable = 1'b1;

    k = 0;
    while (done_cnt < 1 && k < 25000) begin @(negedge clk); k++; end
    chk("frame1_done_seen", 32'(done_cnt >= 1), 32'd1);

    k = 0;
    while (!(done_cnt >= 1 && bus.panel_lat && bus.row_addr == 5'd10) && k < 25000) begin
      @(negedge clk); k++;
    end
    chk("row10_reached", 32'(bus.panel_lat && bus.row_addr == 5'd10), 32'd1);
    enable = 1'b0;

    k = 0;
    while (done_cnt < 2 && k < 25000) begin @(negedge clk); k++; end
    chk("frame2_done_seen", 32'(done_cnt >= 2), 32'd1);

    repeat (2) @(negedge clk);
    chk("end_busy",   32'(busy),           32'd0);
    chk("end_oe_n",   32'(bus.panel_oe_n), 32'd1);
    chk("end_mem_re", 32'(bus.mem_re),     32'd0);
    chk("rgb_q_left", 32'(rgb_q.size()),   32'd0);
    chk("lat_q_left", 32'(lat_q.size()),   32'd0);
    chk("oe_q_left",  32'(oe_q.size()),    32'd0);
    repeat (20) @(negedge clk);
    chk("idle_stays", 32'(busy), 32'd0);
    chk("frame_count", 32'(done_cnt), 32'd2);
    mon_en = 1'b0;

    // Reset in the middle of SHIFT, then restart with enable held
    enable = 1'b1;
    repeat (50) @(negedge clk);
    chk("pre_rst_shifting", 32'(busy && bus.mem_addr != 12'd0 && bus.mem_re), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe_n",      32'(bus.panel_oe_n), 32'd1);
    chk("mid_rst_panel_clk", 32'(bus.panel_clk),  32'd0);
    chk("mid_rst_mem_re",    32'(bus.mem_re),     32'd0);
    chk("mid_rst_busy",      32'(busy),           32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("restart_busy",     32'(busy),         32'd1);
    chk("restart_mem_re",   32'(bus.mem_re),   32'd1);
    chk("restart_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    chk("restart_fetch2_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    chk("restart_shift_addr", 32'(bus.mem_addr), 32'd1);
    chk("restart_shift_rgb",
        32'({bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1}), 32'b101001);

    rst = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
